// File: rtl/calc_engine.sv
// calc_engine: keypad calculator datapath. It accumulates decimal digit entry,
// holds a signed register file and sequences two-register ALU operations. It
// presents a sign/magnitude value for the seven-segment display decoder.
//
// Build option: define CALC_MUL_EN to make opcode 7 a signed multiply with an
// overflow check on truncation. Without it, opcode 7 is a register move
// (R[a] <- R[b]) and no multiplier is built.
module calc_engine #(
    parameter  int WIDTH = 9,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             dig_strobe,
    input  logic [3:0]       digit,
    input  logic             op_strobe,
    input  logic [2:0]       opcode,
    input  logic             reg_strobe,
    input  logic [RW-1:0]    reg_num,
    input  logic             clr_strobe,
    output logic             busy,
    output logic             result_valid,
    output logic             ovf,
    output logic [WIDTH-1:0] disp_mag,
    output logic             disp_neg
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_SEL_A, S_SEL_B, S_EXEC, S_WB, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NEG = 3'd5,
        OP_SHL = 3'd6,
        OP_X7  = 3'd7   // MUL or MOV depending on CALC_MUL_EN
    } op_t;

    // Largest value that decimal entry may reach (most positive signed value).
    localparam logic [WIDTH+3:0] ENTRY_MAX = (WIDTH+4)'(2**(WIDTH-1) - 1);

    state_t                  state;
    op_t                     op_q;
    logic signed [WIDTH-1:0] regs [NREGS];
    logic        [WIDTH-1:0] entry;
    logic signed [WIDTH-1:0] result;
    logic        [RW-1:0]    a_idx;
    logic        [RW-1:0]    b_idx;
    logic        [RW-1:0]    show_idx;
    logic                    show_reg;   // display a register after a display-only reg strobe

    logic signed [WIDTH-1:0] opa, opb, sum, diff;
    logic signed [WIDTH-1:0] exec_res;
    logic                    exec_ovf;
    logic        [WIDTH-1:0] entry_base;
    logic        [WIDTH+3:0] entry_wide;
    logic                    digit_fits;
    logic                    can_start;  // states that accept digit entry and op start
    logic signed [WIDTH-1:0] disp_src;
`ifdef CALC_MUL_EN
    logic signed [2*WIDTH-1:0] prod;
`endif

    // Operation start and digit entry are only accepted in IDLE, ENTRY and DONE.
    assign can_start = (state == S_IDLE) || (state == S_ENTRY) || (state == S_DONE);

    // Next entry value; a digit typed after a completed operation starts a new number.
    always_comb begin
        entry_base = (state == S_DONE) ? '0 : entry;
        entry_wide = {4'b0, entry_base} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digit};
        digit_fits = (entry_wide <= ENTRY_MAX);
    end

    // ALU: result and overflow for the latched opcode and operand registers.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        exec_res = '0;
        exec_ovf = 1'b0;
        opa      = regs[a_idx];
        opb      = regs[b_idx];
        sum      = opa + opb;
        diff     = opa - opb;
`ifdef CALC_MUL_EN
        prod     = (2*WIDTH)'(opa) * (2*WIDTH)'(opb);
`endif
        unique case (op_q)
            OP_ADD: begin
                exec_res = sum;
                exec_ovf = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = diff;
                exec_ovf = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: exec_res = opa & opb;
            OP_OR:  exec_res = opa | opb;
            OP_XOR: exec_res = opa ^ opb;
            OP_NEG: begin
                exec_res = -opa;
                exec_ovf = (opa == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_SHL: begin
                exec_res = {opa[WIDTH-2:0], 1'b0};
                exec_ovf = (opa[WIDTH-1] != opa[WIDTH-2]);
            end
            OP_X7: begin
`ifdef CALC_MUL_EN
                exec_res = prod[WIDTH-1:0];
                // Truncation is lossless only if the discarded bits all copy the new sign bit.
                exec_ovf = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
`else
                exec_res = opb;
`endif
            end
            default: ;
        endcase
    end

    // Control FSM, register file, entry accumulator and status flags.
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op_q         <= OP_ADD;
            entry        <= '0;
            result       <= '0;
            a_idx        <= '0;
            b_idx        <= '0;
            show_idx     <= '0;
            show_reg     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            ovf          <= 1'b0;
            // NOTE: the register file is reset as well, since cleared registers are part of the user-visible state.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments so every read in this block sees the pre-edge values.
            result_valid <= 1'b0;
            unique case (state)
                S_EXEC: begin
                    // All strobes, including clr, are dropped while the operation runs.
                    result       <= exec_res;
                    ovf          <= ovf | exec_ovf;
                    result_valid <= 1'b1;
                    state        <= S_WB;
                end
                S_WB: begin
                    regs[a_idx] <= result;
                    busy        <= 1'b0;
                    state       <= S_DONE;
                end
                default: begin
                    // Priority clr > op > reg > dig; lower strobes in the same cycle are dropped.
                    if (clr_strobe) begin
                        state    <= S_IDLE;
                        entry    <= '0;
                        ovf      <= 1'b0;
                        show_reg <= 1'b0;
                    end else if (op_strobe) begin
                        if (can_start) begin
                            op_q     <= op_t'(opcode);
                            entry    <= '0;
                            ovf      <= 1'b0;
                            show_reg <= 1'b0;
                            state    <= S_SEL_A;
                        end
                    end else if (reg_strobe) begin
                        unique case (state)
                            S_ENTRY: begin
                                regs[reg_num] <= $signed(entry);
                                entry         <= '0;
                                state         <= S_IDLE;
                            end
                            S_IDLE, S_DONE: begin
                                show_idx <= reg_num;
                                show_reg <= 1'b1;
                            end
                            S_SEL_A: begin
                                a_idx <= reg_num;
                                if (op_q == OP_NEG || op_q == OP_SHL) begin
                                    busy  <= 1'b1;
                                    state <= S_EXEC;
                                end else begin
                                    state <= S_SEL_B;
                                end
                            end
                            S_SEL_B: begin
                                b_idx <= reg_num;
                                busy  <= 1'b1;
                                state <= S_EXEC;
                            end
                            default: ;
                        endcase
                    end else if (dig_strobe) begin
                        if (can_start && digit <= 4'd9) begin
                            entry    <= digit_fits ? entry_wide[WIDTH-1:0] : entry_base;
                            show_reg <= 1'b0;
                            state    <= S_ENTRY;
                        end
                    end
                end
            endcase
        end
    end

    // Display source selection and sign/magnitude conversion.
    always_comb begin
        disp_src = $signed(entry);
        if (show_reg) begin
            disp_src = regs[show_idx];
        end else if (state == S_EXEC || state == S_WB || state == S_DONE) begin
            disp_src = result;
        end
        disp_neg = disp_src[WIDTH-1];
        // The most negative value negates to itself, which reads as 2^(WIDTH-1) unsigned.
        disp_mag = disp_src[WIDTH-1] ? WIDTH'(-disp_src) : disp_src;
    end

endmodule

// File: doc/calc_engine.md
# calc_engine

Parametrised calculator datapath for the keypad calculator. Replaces the separate operand buffer, read FSM, register file and ALU with one block. The block accumulates decimal digit entry and stores operands in a register file of NREGS signed registers. It sequences two-register operations and presents a sign/magnitude display value to the seven-segment decoder. It sits between the key/opcode/register decoders and the display decoder, all on `hwclk`.

## Interface
- `WIDTH`, 9: register and result width, two's complement; range −2^(WIDTH−1) .. 2^(WIDTH−1)−1.
- `NREGS`, 8: register count, power of two, ≥2; `RW = $clog2(NREGS)`.
- `hwclk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `dig_strobe` in 1: one-cycle pulse, `digit` is valid.
- `digit` in 4: decimal digit 0–9; values 10–15 are ignored.
- `op_strobe` in 1: one-cycle pulse, `opcode` is valid.
- `opcode` in 3: operation select (see Operation).
- `reg_strobe` in 1: one-cycle pulse, `reg_num` is valid.
- `reg_num` in RW: register index.
- `clr_strobe` in 1: abort/clear.
- `busy` out 1: high in EXEC and WB.
- `result_valid` out 1: one-cycle pulse in WB.
- `ovf` out 1: sticky arithmetic overflow flag.
- `disp_mag` out WIDTH: absolute value of the displayed number.
- `disp_neg` out 1: displayed number is negative.

## Operation
- States: IDLE, ENTRY, SEL_A, SEL_B, EXEC, WB, DONE.
- **Reset:** state IDLE; entry=0; all registers=0; latched a/b/opcode=0; `busy`=0, `result_valid`=0, `ovf`=0, `disp_mag`=0, `disp_neg`=0.
- **Strobe priority** when several are high in the same cycle: `clr` > `op` > `reg` > `dig`. Lower-priority strobes that cycle are dropped.
- **clr:** from any state except EXEC/WB → IDLE, entry=0, `ovf`=0. Registers are untouched. In EXEC/WB, `clr` is ignored.
- **Digit entry:**
  - `dig` in IDLE/ENTRY/DONE → ENTRY, entry ← entry·10 + digit.
  - If the product exceeds 2^(WIDTH−1)−1, the digit is dropped and entry is unchanged; no flag is raised.
  - Entering from DONE starts from entry=0.
- **Store:** `reg` in ENTRY → R[reg_num] ← entry, entry=0, → IDLE. In IDLE/DONE, `reg` only changes the display to R[reg_num]; state is unchanged.
- **Operation start:** `op` in IDLE/ENTRY/DONE latches opcode, entry=0, `ovf`=0, → SEL_A.
- **SEL_A:** `reg` latches a. Unary ops (NEG, SHL) → EXEC; all others → SEL_B.
- **SEL_B:** `reg` latches b → EXEC. `dig`/`op` are ignored in SEL_A and SEL_B.
- **EXEC:** computes a registered result.
- **WB:** R[a] ← result, `result_valid`=1 → DONE. a and b may be the same register.
- **Opcodes:**
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NEG (−A)
  - 6 SHL (A<<1)
  - 7 MUL or MOV (see Configuration)
- **Overflow:** results wrap to WIDTH bits. `ovf` is set by:
  - signed ADD/SUB overflow;
  - NEG of the most negative value;
  - SHL when the sign bit changes;
  - MUL when the full product does not fit.
  - `ovf` holds until the next `op` or `clr`.
- **Display source:** entry in IDLE/ENTRY/SEL_A/SEL_B; result in EXEC/WB/DONE; R[reg_num] after a display-only `reg`.
- **Display format:** `disp_neg` = source sign bit; `disp_mag` = |source|. The most negative value shows as magnitude 2^(WIDTH−1).

## Timing
- All strobes are sampled on the rising edge of `hwclk`. All outputs are registered or decoded from registered state.
- **Operation latency:** final select strobe sampled at edge n.
  - Cycle n+1: EXEC, `busy`=1.
  - Edge n+1: result and `ovf` latched.
  - Cycle n+2: WB, `busy`=1, `result_valid`=1.
  - Edge n+2: register written, → DONE.
  - The new R[a] is readable from cycle n+3.
- Any strobe during EXEC/WB, including `clr`, is dropped.
- **Reset mid-operation:** returns to IDLE on assertion, with no write-back.

## Configuration
- `CALC_MUL_EN` defined: opcode 7 = signed MUL, low WIDTH bits, `ovf` on truncation. Implemented as a combinational WIDTH×WIDTH multiply in EXEC.
- `CALC_MUL_EN` undefined: opcode 7 = MOV (R[a] ← R[b]), `ovf` is never set, and no multiplier is synthesised.

## Test plan
All scenarios use WIDTH=9, NREGS=8.
- **Reset:** reset mid-SEL_B → IDLE; all outputs 0; R0..R7 read back 0 via display-only `reg`.
- **Entry and store:** digits 1,2,3 then `reg`=2 → R2=123; digits 2,5,6 → entry saturates at 25, shown as `disp_mag`=25.
- **ADD overflow:** R1=200, R2=100, `op`=ADD, `reg` 1, `reg` 2 → `result_valid` exactly 2 cycles after the second `reg`. R1=300−512=−212 (`disp_neg`=1, `disp_mag`=212), `ovf`=1.
- **SUB and NEG:** R3=5, R4=9, SUB 3,4 → R3=−4, `ovf`=0. NEG 3 → R3=4.
- **Opcode 7:** R5=20, R6=30, opcode 7 on 5,6. With `CALC_MUL_EN` → R5=600 wraps to 88, `ovf`=1. Without it → R5=30, `ovf`=0.
- **Priority and abort:** simultaneous `clr`+`reg` in SEL_B → IDLE, no write. `op`+`dig` together → SEL_A, digit dropped. `clr` during EXEC → ignored, write-back completes.
